// File: rtl/pc_stacked_if.sv
// rtl/pc_stacked_if.sv - control/data bundle between the decoder and pc_stacked
//
// Ports (as seen from the counter, modport slave):
//   D            in  8      data bus: jump target low byte and staged high bytes
//   _pchitmp_in  in  1      active-low, shift D into HITMP
//   _pclo_in     in  1      active-low, load PC[7:0] from D
//   _pc_in       in  1      active-low, unconditional jump
//   _pcc_in      in  1      active-low, jump when cond is set
//   cond         in  1      condition flag for _pcc_in
//   _call        in  1      active-low, jump and push return address
//   _ret         in  1      active-low, pop return address into PC
//   _hold        in  1      active-low, stall PC and stack
//   PC           out WIDTH  current instruction address
//   stk_empty    out 1      stack holds no entries
//   stk_full     out 1      stack holds DEPTH entries
//   stk_err      out 1      sticky overflow/underflow flag
interface pc_stacked_if #(
    parameter int WIDTH = 16
);
    logic [7:0]       D;
    logic             _pchitmp_in;
    logic             _pclo_in;
    logic             _pc_in;
    logic             _pcc_in;
    logic             cond;
    logic             _call;
    logic             _ret;
    logic             _hold;
    logic [WIDTH-1:0] PC;
    logic             stk_empty;
    logic             stk_full;
    logic             stk_err;

    modport master (
        output D, _pchitmp_in, _pclo_in, _pc_in, _pcc_in, cond, _call, _ret, _hold,
        input  PC, stk_empty, stk_full, stk_err
    );

    modport slave (
        input  D, _pchitmp_in, _pclo_in, _pc_in, _pcc_in, cond, _call, _ret, _hold,
        output PC, stk_empty, stk_full, stk_err
    );
endinterface

// File: rtl/pc_stacked.sv
// rtl/pc_stacked.sv - parametrised program counter with staged high bytes and return stack
//
// Ports:
//   clk   in  1   rising-edge clock
//   _MR   in  1   master reset, asynchronous, active-low
//   bus   slave   pc_stacked_if: strobes, data bus, PC and stack status
//
// Parameters:
//   WIDTH  PC width in bits, multiple of 8, at least 16
//   DEPTH  number of return-address stack entries, at least 1
module pc_stacked #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         _MR,
    pc_stacked_if.slave  bus
);
    localparam int HW  = WIDTH - 8;
    localparam int SPW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_d;
    logic [WIDTH-1:0] pc_inc;
    logic [WIDTH-1:0] target;
    logic [HW-1:0]    hitmp_q;
    logic [HW-1:0]    hitmp_shift;
    logic [SPW-1:0]   sp_q;
    logic [SPW-1:0]   sp_d;
    logic [WIDTH-1:0] stk_q [DEPTH];
    logic             err_q;
    logic             err_d;
    logic             push;
    logic             pop;
    logic             empty_w;
    logic             full_w;

    // HITMP shifts a byte in from the bottom; at WIDTH=16 it holds exactly one byte.
    if (HW == 8) begin : g_hi_load
        assign hitmp_shift = bus.D;
    end else begin : g_hi_shift
        assign hitmp_shift = {hitmp_q[HW-9:0], bus.D};
    end

    // Jumps use the HITMP value held before this edge.
    assign target  = {hitmp_q, bus.D};
    assign pc_inc  = pc_q + WIDTH'(1);
    assign empty_w = (sp_q == '0);
    assign full_w  = (sp_q == SPW'(DEPTH));

    // Strict priority: hold > ret > call > pc_in > pcc_in > pclo_in > increment.
    always_comb begin
        pc_d  = pc_q;
        sp_d  = sp_q;
        err_d = err_q;
        push  = 1'b0;
        pop   = 1'b0;
        if (!bus._hold) begin
            pc_d = pc_q;
        end else if (!bus._ret) begin
            if (!empty_w) begin
                pc_d = stk_q[0];
                pop  = 1'b1;
                sp_d = sp_q - SPW'(1);
            end else begin
                pc_d  = pc_inc;
                err_d = 1'b1;
            end
        end else if (!bus._call) begin
            pc_d = target;
            if (!full_w) begin
                push = 1'b1;
                sp_d = sp_q + SPW'(1);
            end else begin
                err_d = 1'b1;
            end
        end else if (!bus._pc_in) begin
            pc_d = target;
        end else if (!bus._pcc_in) begin
            pc_d = bus.cond ? target : pc_inc;
        end else if (!bus._pclo_in) begin
            pc_d = {pc_q[WIDTH-1:8], bus.D};
        end else begin
            pc_d = pc_inc;
        end
    end

    always_ff @(posedge clk or negedge _MR) begin
        if (!_MR) begin
            pc_q    <= '0;
            hitmp_q <= '0;
            sp_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            sp_q  <= sp_d;
            err_q <= err_d;
            // HITMP loads independently of hold and of every PC action.
            if (!bus._pchitmp_in) begin
                hitmp_q <= hitmp_shift;
            end
        end
    end

    // Stack as a shift register with the top at entry 0, so no SP-indexed
    // addressing is needed. Contents need no reset; SP alone says what is valid.
    always_ff @(posedge clk) begin
        if (_MR) begin
            if (push) begin
                stk_q[0] <= pc_inc;
                for (int i = 1; i < DEPTH; i++) begin
                    stk_q[i] <= stk_q[i-1];
                end
            end else if (pop) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    stk_q[i] <= stk_q[i+1];
                end
            end
        end
    end

    assign bus.PC        = pc_q;
    assign bus.stk_empty = empty_w;
    assign bus.stk_full  = full_w;
    assign bus.stk_err   = err_q;
endmodule

// File: doc/pc_stacked.md
# pc_stacked

Parametrised program counter, the next generation of the 16-bit `pc`. The counter width is set by a parameter and upper address bytes are staged through an 8-bit data bus. It adds conditional jump, stall, and a hardware call/return stack. It sits between the control decoder and program memory and drives the instruction address every cycle.

## Interface
Parameters:
- WIDTH, default 16: PC width in bits. Must be a multiple of 8 and at least 16.
- DEPTH, default 4: number of return-address stack entries. Must be at least 1.

Ports:
- clk  in  1: rising-edge clock.
- _MR  in  1: master reset. Asynchronous, active-low.
- D  in  8: data bus. Supplies the jump target low byte and the staged high bytes.
- _pchitmp_in  in  1: active-low. Shifts D into HITMP.
- _pclo_in  in  1: active-low. Loads the PC low byte from D.
- _pc_in  in  1: active-low. Unconditional jump.
- _pcc_in  in  1: active-low. Conditional jump, qualified by `cond`.
- cond  in  1: condition flag for `_pcc_in`.
- _call  in  1: active-low. Jump and push the return address.
- _ret  in  1: active-low. Pop the return address into PC.
- _hold  in  1: active-low. Stalls PC and stack.
- PC  out  WIDTH: current address.
- stk_empty  out  1: stack holds 0 entries.
- stk_full  out  1: stack holds DEPTH entries.
- stk_err  out  1: sticky over/underflow flag.

## Operation
- HITMP is a WIDTH-8 bit staging register.
  - When `_pchitmp_in` is low, HITMP <= {HITMP[WIDTH-17:0], D}.
  - For WIDTH=16 this reduces to a plain load.
  - Jump target T = {HITMP, D}.
- HITMP updates on every edge where `_pchitmp_in` is low, regardless of `_hold` and of any other action.
- A jump on the same edge uses the old HITMP value.
- PC next-state. Lowest-numbered active line wins; the other strobes are ignored that edge:
  1. `_hold` low: PC and stack unchanged.
  2. `_ret` low:
     - Stack non-empty: PC <= top entry, then pop.
     - Stack empty: PC <= PC+1 and stk_err is set.
  3. `_call` low:
     - Stack not full: push PC+1, then PC <= T.
     - Stack full: PC <= T, the push is dropped, and stk_err is set.
  4. `_pc_in` low: PC <= T.
  5. `_pcc_in` low: PC <= T if cond=1, else PC <= PC+1.
  6. `_pclo_in` low: PC[7:0] <= D; upper bytes unchanged; no increment.
  7. Otherwise: PC <= PC+1.
- Loading HITMP alone does not block the increment.
- Arithmetic is modulo 2^WIDTH.
  - PC+1 from all-ones gives 0, with no flag.
  - A call at all-ones pushes 0.
- The stack is LIFO with a stack pointer SP in 0..DEPTH.
  - stk_empty = (SP==0).
  - stk_full = (SP==DEPTH).
- stk_err is cleared only by `_MR`.

## Timing
- All state changes on the clk rising edge. Nothing changes on the falling edge.
- All outputs are registered, or decoded from SP only.
- Latency: a strobe sampled at edge N appears on PC after edge N.
- One push or one pop per edge, at most.
- `_MR` low asynchronously forces:
  - PC=0, HITMP=0, SP=0;
  - stk_empty=1, stk_full=0, stk_err=0.
- Stack entry contents after reset are don't-care.
- While `_MR` is low, clock edges have no effect.
- Assertion of `_MR` mid-sequence between edges clears the state immediately, not at the next edge.
- Release of `_MR` is synchronous in effect: the first increment occurs at the first rising edge after release.
- Before the first `_MR` assertion, PC is X.

## Test plan
- Reset and count (WIDTH=16):
  - `_MR` low -> PC=0x0000 with no clock edge needed.
  - Release, 2 edges -> PC=0x0002.
  - Falling edges leave PC unchanged.
- Staged jump (WIDTH=24):
  - `_pchitmp_in` with D=0x12, then with D=0x34 -> PC still increments each edge.
  - `_pc_in` with D=0x56 -> PC=0x123456.
  - `_pclo_in` with D=0xFE -> PC=0x1234FE.
  - Free-run count -> 0x1234FF, then 0x123500.
- Conditional and hold:
  - `_pcc_in` with cond=0 at PC=0x0010 -> PC=0x0011.
  - `_pcc_in` with cond=1, HITMP=0xAB, D=0xCD -> PC=0xABCD.
  - `_hold` low together with `_pc_in` for 3 edges -> PC stays 0xABCD.
- Call/return (DEPTH=2):
  - Call at 0x0100 to 0x2000 -> PC=0x2000.
  - Call again from 0x2000 to 0x3000 -> PC=0x3000, stk_full=1.
  - Third call to 0x4000 -> PC=0x4000, stk_err=1.
  - Ret -> PC=0x2001; ret -> PC=0x0101, stk_empty=1.
  - Ret with empty stack -> PC=0x0102, stk_err stays 1.
- Priority: `_ret`, `_call` and `_pc_in` all low, stack holding 0x0042 -> PC=0x0042 and SP decrements.
- Wrap: free-run 3*2^16 edges from reset (WIDTH=16) -> PC equals edge count mod 2^16 at every edge.
